// File: rtl/decode_stage_reg_pkg.sv
// Decode stage shared types: opcodes, control encodings and the
// ID/EX control bundle.
package decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam int ALU_SRC_W = 2;
  localparam int ALU_OP_W  = 4;
  localparam int BR_W      = 2;
  localparam int RIS_W     = 2;
  localparam int DWE_W     = 4;

  // bit0: operand b is imm, bit1: operand a is pc
  localparam logic [ALU_SRC_W-1:0] SRC_RR  = 2'b00;
  localparam logic [ALU_SRC_W-1:0] SRC_IMM = 2'b01;
  localparam logic [ALU_SRC_W-1:0] SRC_PCI = 2'b11;

  localparam logic [BR_W-1:0] BR_NONE = 2'd0;
  localparam logic [BR_W-1:0] BR_COND = 2'd1;
  localparam logic [BR_W-1:0] BR_JAL  = 2'd2;
  localparam logic [BR_W-1:0] BR_JALR = 2'd3;

  localparam logic [RIS_W-1:0] RIS_ALU = 2'd0;
  localparam logic [RIS_W-1:0] RIS_MEM = 2'd1;
  localparam logic [RIS_W-1:0] RIS_PC4 = 2'd2;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
    ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef struct packed {
    logic [ALU_SRC_W-1:0] alu_src;
    alu_op_e              alu_op;
    logic [BR_W-1:0]      branch;
    logic [RIS_W-1:0]     reg_in_sel;
    logic [DWE_W-1:0]     dwe;
    logic [2:0]           func3;
    logic                 mem_reg;
    logic                 reg_wr;
  } idex_ctrl_t;

  function automatic alu_op_e alu_op_of(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_e op;
    unique case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_reg_if.sv
// Decode stage bus: IF/ID input, writeback, pipeline control,
// debug port and the registered ID/EX boundary.
interface decode_stage_reg_if #(
  parameter int XLEN = 32
);
  logic            id_valid_in;
  logic [31:0]     id_idata_in;
  logic [XLEN-1:0] id_pc_in;
  logic            wb_we_in;
  logic [4:0]      wb_rd_in;
  logic [XLEN-1:0] wb_data_in;
  logic            ex_hold_in;
  logic            flush_in;
  logic [4:0]      dbg_sel_in;
  logic            id_stall_out;
  logic            ex_valid_out;
  logic [1:0]      ex_alu_src_out;
  logic [3:0]      ex_alu_op_out;
  logic [1:0]      ex_branch_out;
  logic [1:0]      ex_reg_in_sel_out;
  logic [3:0]      ex_dwe_out;
  logic [2:0]      ex_func3_out;
  logic            ex_mem_reg_out;
  logic            ex_reg_wr_out;
  logic [XLEN-1:0] ex_rv1_out;
  logic [XLEN-1:0] ex_rv2_out;
  logic [XLEN-1:0] ex_imm_out;
  logic [XLEN-1:0] ex_pc_out;
  logic [4:0]      ex_rd_out;
  logic [4:0]      ex_rs1_out;
  logic [4:0]      ex_rs2_out;
  logic [XLEN-1:0] dbg_rdata_out;

  modport master (
    output id_valid_in, id_idata_in, id_pc_in,
    output wb_we_in, wb_rd_in, wb_data_in,
    output ex_hold_in, flush_in, dbg_sel_in,
    input  id_stall_out, ex_valid_out,
    input  ex_alu_src_out, ex_alu_op_out, ex_branch_out,
    input  ex_reg_in_sel_out, ex_dwe_out, ex_func3_out,
    input  ex_mem_reg_out, ex_reg_wr_out,
    input  ex_rv1_out, ex_rv2_out, ex_imm_out, ex_pc_out,
    input  ex_rd_out, ex_rs1_out, ex_rs2_out,
    input  dbg_rdata_out
  );

  modport slave (
    input  id_valid_in, id_idata_in, id_pc_in,
    input  wb_we_in, wb_rd_in, wb_data_in,
    input  ex_hold_in, flush_in, dbg_sel_in,
    output id_stall_out, ex_valid_out,
    output ex_alu_src_out, ex_alu_op_out, ex_branch_out,
    output ex_reg_in_sel_out, ex_dwe_out, ex_func3_out,
    output ex_mem_reg_out, ex_reg_wr_out,
    output ex_rv1_out, ex_rv2_out, ex_imm_out, ex_pc_out,
    output ex_rd_out, ex_rs1_out, ex_rs2_out,
    output dbg_rdata_out
  );
endinterface

// File: rtl/decode_stage_reg_id_ctrl_decode.sv
// Combinational RV32I instruction decoder: control bundle and
// sign-extended immediate.
module id_ctrl_decode
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output idex_ctrl_t  ctrl,
  output logic [31:0] imm
);
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign op = instr[6:0];
  assign f3 = instr[14:12];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  always_comb begin
    ctrl       = '0;
    ctrl.func3 = f3;
    imm        = '0;
    unique case (1'b1)
      op == OP_LUI: begin
        ctrl.alu_src = SRC_IMM;
        ctrl.alu_op  = ALU_PASSB;
        ctrl.reg_wr  = 1'b1;
        imm          = imm_u;
      end
      op == OP_AUIPC: begin
        ctrl.alu_src = SRC_PCI;
        ctrl.reg_wr  = 1'b1;
        imm          = imm_u;
      end
      op == OP_JAL: begin
        ctrl.alu_src    = SRC_PCI;
        ctrl.branch     = BR_JAL;
        ctrl.reg_in_sel = RIS_PC4;
        ctrl.reg_wr     = 1'b1;
        imm             = imm_j;
      end
      op == OP_JALR: begin
        ctrl.alu_src    = SRC_IMM;
        ctrl.branch     = BR_JALR;
        ctrl.reg_in_sel = RIS_PC4;
        ctrl.reg_wr     = 1'b1;
        imm             = imm_i;
      end
      op == OP_BRANCH: begin
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = BR_COND;
        imm         = imm_b;
      end
      op == OP_LOAD: begin
        ctrl.alu_src    = SRC_IMM;
        ctrl.reg_in_sel = RIS_MEM;
        ctrl.mem_reg    = 1'b1;
        ctrl.reg_wr     = 1'b1;
        imm             = imm_i;
      end
      op == OP_STORE: begin
        ctrl.alu_src = SRC_IMM;
        ctrl.dwe     = (f3[1:0] == 2'b00) ? 4'b0001 :
                       (f3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
        imm          = imm_s;
      end
      op == OP_IMM: begin
        ctrl.alu_src = SRC_IMM;
        ctrl.alu_op  = alu_op_of(f3, (f3 == 3'b101) & instr[30]);
        ctrl.reg_wr  = 1'b1;
        imm          = imm_i;
      end
      op == OP_REG: begin
        ctrl.alu_op = alu_op_of(f3, instr[30]);
        ctrl.reg_wr = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/decode_stage_reg.sv
// Decode stage: regfile with write bypass, load-use detection and
// the registered ID/EX boundary.
module decode_stage_reg
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic               clk,
  input logic               rst,
  decode_stage_reg_if.slave bus
);
  localparam int REG_AW = $clog2(NREG);

  typedef logic [REG_AW-1:0] ridx_t;
  typedef logic [XLEN-1:0]   word_t;

  function automatic word_t byp(
    input ridx_t idx, input word_t ent,
    input logic we, input ridx_t wa, input word_t wd
  );
    if (idx == '0) return '0;
    if (we && wa == idx) return wd;
    return ent;
  endfunction

  idex_ctrl_t  dec_ctrl, ld_ctrl;
  logic [31:0] dec_imm;
  logic [4:0]  rs1_f, rs2_f, rd_f;
  ridx_t       rs1_i, rs2_i, wa_i, dbg_i, exrd_i;
  word_t       rv1, rv2, imm_x;
  logic        wr_en, lu;

  word_t rf_q [NREG];
  word_t rf_d [NREG];

  logic       valid_q, valid_d;
  idex_ctrl_t ctrl_q, ctrl_d;
  word_t      rv1_q, rv1_d, rv2_q, rv2_d;
  word_t      imm_q, imm_d, pc_q, pc_d;
  logic [4:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;

  id_ctrl_decode u_dec (
    .instr (bus.id_idata_in),
    .ctrl  (dec_ctrl),
    .imm   (dec_imm)
  );

  assign rs1_f  = bus.id_idata_in[19:15];
  assign rs2_f  = bus.id_idata_in[24:20];
  assign rd_f   = bus.id_idata_in[11:7];
  assign rs1_i  = rs1_f[REG_AW-1:0];
  assign rs2_i  = rs2_f[REG_AW-1:0];
  assign wa_i   = bus.wb_rd_in[REG_AW-1:0];
  assign dbg_i  = bus.dbg_sel_in[REG_AW-1:0];
  assign exrd_i = rd_q[REG_AW-1:0];
  assign imm_x  = XLEN'(signed'(dec_imm));
  assign wr_en  = bus.wb_we_in && (wa_i != '0);

  assign rv1 = byp(rs1_i, rf_q[rs1_i], wr_en, wa_i, bus.wb_data_in);
  assign rv2 = byp(rs2_i, rf_q[rs2_i], wr_en, wa_i, bus.wb_data_in);
  assign bus.dbg_rdata_out =
    byp(dbg_i, rf_q[dbg_i], wr_en, wa_i, bus.wb_data_in);

  assign lu = valid_q && ctrl_q.mem_reg && (exrd_i != '0) &&
              bus.id_valid_in &&
              ((exrd_i == rs1_i) || (exrd_i == rs2_i));

  assign bus.id_stall_out = !bus.flush_in && (bus.ex_hold_in || lu);

  always_comb begin
    rf_d = rf_q;
    if (wr_en) rf_d[wa_i] = bus.wb_data_in;
  end

  always_comb begin
    ld_ctrl = dec_ctrl;
    if (!bus.id_valid_in) begin
      ld_ctrl.reg_wr = 1'b0;
      ld_ctrl.dwe    = '0;
      ld_ctrl.branch = '0;
    end
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    rv1_d   = rv1_q;
    rv2_d   = rv2_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    // flush beats hold; hold beats the load-use bubble
    if (bus.flush_in || (!bus.ex_hold_in && lu)) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      rv1_d   = '0;
      rv2_d   = '0;
      imm_d   = '0;
      pc_d    = '0;
      rd_d    = '0;
      rs1_d   = '0;
      rs2_d   = '0;
    end else if (!bus.ex_hold_in) begin
      valid_d = bus.id_valid_in;
      ctrl_d  = ld_ctrl;
      rv1_d   = rv1;
      rv2_d   = rv2;
      imm_d   = imm_x;
      pc_d    = bus.id_pc_in;
      rd_d    = rd_f;
      rs1_d   = rs1_f;
      rs2_d   = rs2_f;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_q    <= '{default: '0};
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rv1_q   <= '0;
      rv2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      rf_q    <= rf_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rv1_q   <= rv1_d;
      rv2_q   <= rv2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
    end
  end

  assign bus.ex_valid_out      = valid_q;
  assign bus.ex_alu_src_out    = ctrl_q.alu_src;
  assign bus.ex_alu_op_out     = ctrl_q.alu_op;
  assign bus.ex_branch_out     = ctrl_q.branch;
  assign bus.ex_reg_in_sel_out = ctrl_q.reg_in_sel;
  assign bus.ex_dwe_out        = ctrl_q.dwe;
  assign bus.ex_func3_out      = ctrl_q.func3;
  assign bus.ex_mem_reg_out    = ctrl_q.mem_reg;
  assign bus.ex_reg_wr_out     = ctrl_q.reg_wr;
  assign bus.ex_rv1_out        = rv1_q;
  assign bus.ex_rv2_out        = rv2_q;
  assign bus.ex_imm_out        = imm_q;
  assign bus.ex_pc_out         = pc_q;
  assign bus.ex_rd_out         = rd_q;
  assign bus.ex_rs1_out        = rs1_q;
  assign bus.ex_rs2_out        = rs2_q;
endmodule

// File: tb/tb_decode_stage_reg.sv
// Directed bench for decode_stage_reg: 32-entry and 16-entry
// register file instances driven from hand-built vectors.
module tb_decode_stage_reg;
  localparam logic [31:0] I_ADDI = 32'h0050_0293;
  localparam logic [31:0] I_LW   = 32'h0002_A303;
  localparam logic [31:0] I_ADD7 = 32'h0063_03B3;
  localparam logic [31:0] I_ADD0 = 32'h0000_0033;
  localparam logic [31:0] I_ADD1 = 32'h000A_80B3;

  logic clk = 1'b0;
  logic rst, rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decode_stage_reg_if #(.XLEN(32)) bus ();
  decode_stage_reg_if #(.XLEN(32)) bus_b ();

  decode_stage_reg #(.XLEN(32), .NREG(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  decode_stage_reg #(.XLEN(32), .NREG(16)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.slave)
  );

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a;
    bus.id_valid_in = 1'b0;
    bus.id_idata_in = '0;
    bus.id_pc_in    = '0;
    bus.wb_we_in    = 1'b0;
    bus.wb_rd_in    = '0;
    bus.wb_data_in  = '0;
    bus.ex_hold_in  = 1'b0;
    bus.flush_in    = 1'b0;
    bus.dbg_sel_in  = '0;
  endtask

  task automatic idle_b;
    bus_b.id_valid_in = 1'b0;
    bus_b.id_idata_in = '0;
    bus_b.id_pc_in    = '0;
    bus_b.wb_we_in    = 1'b0;
    bus_b.wb_rd_in    = '0;
    bus_b.wb_data_in  = '0;
    bus_b.ex_hold_in  = 1'b0;
    bus_b.flush_in    = 1'b0;
    bus_b.dbg_sel_in  = '0;
  endtask

  initial begin
    idle_a();
    idle_b();
    rst   = 1'b1;
    rst_b = 1'b1;
    step();
    step();
    rst   = 1'b0;
    rst_b = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.ex_valid_out), 32'd0);
    chk("rst_rd", 32'(bus.ex_rd_out), 32'd0);
    chk("rst_imm", bus.ex_imm_out, 32'd0);
    chk("rst_stall", 32'(bus.id_stall_out), 32'd0);

    // addi x5,x0,5
    bus.id_valid_in = 1'b1;
    bus.id_idata_in = I_ADDI;
    bus.id_pc_in    = 32'h100;
    step();
    chk("addi_valid", 32'(bus.ex_valid_out), 32'd1);
    chk("addi_rd", 32'(bus.ex_rd_out), 32'd5);
    chk("addi_imm", bus.ex_imm_out, 32'd5);
    chk("addi_wr", 32'(bus.ex_reg_wr_out), 32'd1);
    chk("addi_rv1", bus.ex_rv1_out, 32'd0);
    chk("addi_pc", bus.ex_pc_out, 32'h100);
    chk("addi_dwe", 32'(bus.ex_dwe_out), 32'd0);

    // lw x6,0(x5) then add x7,x6,x6
    bus.id_idata_in = I_LW;
    bus.id_pc_in    = 32'h104;
    step();
    chk("lw_memreg", 32'(bus.ex_mem_reg_out), 32'd1);
    chk("lw_rd", 32'(bus.ex_rd_out), 32'd6);
    bus.id_idata_in = I_ADD7;
    bus.id_pc_in    = 32'h108;
    #1;
    chk("lu_stall", 32'(bus.id_stall_out), 32'd1);
    step();
    chk("lu_bub_valid", 32'(bus.ex_valid_out), 32'd0);
    chk("lu_bub_rd", 32'(bus.ex_rd_out), 32'd0);
    chk("lu_bub_pc", bus.ex_pc_out, 32'd0);
    bus.wb_we_in   = 1'b1;
    bus.wb_rd_in   = 5'd6;
    bus.wb_data_in = 32'hDEAD_BEEF;
    bus.dbg_sel_in = 5'd6;
    #1;
    chk("lu_stall_clr", 32'(bus.id_stall_out), 32'd0);
    chk("dbg_byp", bus.dbg_rdata_out, 32'hDEAD_BEEF);
    step();
    bus.wb_we_in = 1'b0;
    chk("add_valid", 32'(bus.ex_valid_out), 32'd1);
    chk("add_rd", 32'(bus.ex_rd_out), 32'd7);
    chk("byp_rv1", bus.ex_rv1_out, 32'hDEAD_BEEF);
    chk("byp_rv2", bus.ex_rv2_out, 32'hDEAD_BEEF);
    step();
    chk("rf_rv1", bus.ex_rv1_out, 32'hDEAD_BEEF);

    // write to x0 is discarded
    bus.wb_we_in    = 1'b1;
    bus.wb_rd_in    = 5'd0;
    bus.wb_data_in  = 32'h1234;
    bus.dbg_sel_in  = 5'd0;
    bus.id_idata_in = I_ADD0;
    #1;
    chk("x0_dbg_byp", bus.dbg_rdata_out, 32'd0);
    step();
    bus.wb_we_in = 1'b0;
    chk("x0_rv1", bus.ex_rv1_out, 32'd0);
    chk("x0_rv2", bus.ex_rv2_out, 32'd0);
    #1;
    chk("x0_dbg", bus.dbg_rdata_out, 32'd0);

    // flush wins over hold
    bus.id_idata_in = I_ADDI;
    bus.flush_in    = 1'b1;
    bus.ex_hold_in  = 1'b1;
    #1;
    chk("fh_stall", 32'(bus.id_stall_out), 32'd0);
    step();
    chk("fh_valid", 32'(bus.ex_valid_out), 32'd0);
    chk("fh_rd", 32'(bus.ex_rd_out), 32'd0);
    bus.flush_in   = 1'b0;
    bus.ex_hold_in = 1'b0;
    step();
    chk("fh_reload", 32'(bus.ex_rd_out), 32'd5);

    // hold for 3 cycles with a writeback to x9 underneath
    bus.ex_hold_in  = 1'b1;
    bus.id_idata_in = I_ADD7;
    bus.wb_we_in    = 1'b1;
    bus.wb_rd_in    = 5'd9;
    bus.wb_data_in  = 32'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      bus.wb_we_in = 1'b0;
      chk("hold_rd", 32'(bus.ex_rd_out), 32'd5);
      chk("hold_imm", bus.ex_imm_out, 32'd5);
      chk("hold_stall", 32'(bus.id_stall_out), 32'd1);
    end
    bus.dbg_sel_in = 5'd9;
    #1;
    chk("hold_wb", bus.dbg_rdata_out, 32'h55);
    bus.ex_hold_in = 1'b0;
    step();
    chk("unhold_rd", 32'(bus.ex_rd_out), 32'd7);

    // invalid slot loads with side effects masked
    bus.id_valid_in = 1'b0;
    bus.id_idata_in = I_ADDI;
    step();
    chk("inv_valid", 32'(bus.ex_valid_out), 32'd0);
    chk("inv_wr", 32'(bus.ex_reg_wr_out), 32'd0);
    chk("inv_rd", 32'(bus.ex_rd_out), 32'd5);

    // reset during a load-use stall
    bus.id_valid_in = 1'b1;
    bus.id_idata_in = I_LW;
    step();
    bus.id_idata_in = I_ADD7;
    #1;
    chk("rs_stall", 32'(bus.id_stall_out), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rs_valid", 32'(bus.ex_valid_out), 32'd0);
    chk("rs_rd", 32'(bus.ex_rd_out), 32'd0);
    chk("rs_memreg", 32'(bus.ex_mem_reg_out), 32'd0);
    chk("rs_rv1", bus.ex_rv1_out, 32'd0);
    chk("rs_stall_now", 32'(bus.id_stall_out), 32'd0);
    for (int r = 1; r < 32; r++) begin
      bus.dbg_sel_in = 5'(r);
      #1;
      chk("rs_rf", bus.dbg_rdata_out, 32'd0);
    end

    // 16-entry file: x21 aliases x5
    bus_b.wb_we_in   = 1'b1;
    bus_b.wb_rd_in   = 5'd21;
    bus_b.wb_data_in = 32'hA5A5_A5A5;
    bus_b.dbg_sel_in = 5'd5;
    #1;
    chk("e_dbg_byp", bus_b.dbg_rdata_out, 32'hA5A5_A5A5);
    step();
    bus_b.wb_we_in = 1'b0;
    #1;
    chk("e_dbg5", bus_b.dbg_rdata_out, 32'hA5A5_A5A5);
    bus_b.dbg_sel_in = 5'd21;
    #1;
    chk("e_dbg21", bus_b.dbg_rdata_out, 32'hA5A5_A5A5);
    bus_b.id_valid_in = 1'b1;
    bus_b.id_idata_in = I_ADD1;
    step();
    chk("e_rv1", bus_b.ex_rv1_out, 32'hA5A5_A5A5);
    chk("e_rd", 32'(bus_b.ex_rd_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
